brick_ram_arbiter: RTL
======================

# brick_ram_arbiter

Round-robin read arbiter and write sequencer for the brick sprite RAM (4-bit pixel, 2700-entry, one-cycle registered read). It shares the single RAM read port among up to N_REQ sprite-draw requesters, routes loader writes to the write port, and returns tagged read data to the winning requester. It sits between the per-brick draw engines / palette loader and the brick RAM instance, and it drives all of the RAM's address, data and write-enable inputs.

## Interface
- N_REQ, 4: number of read requesters (2..8)
- ADDR_W, 19: RAM address width
- DATA_W, 4: pixel width
- MEM_DEPTH, 2700: valid addresses are 0..MEM_DEPTH-1

- CLK  in  1  system clock, rising edge
- RESET_N  in  1  asynchronous, active-low reset
- req  in  N_REQ  per-requester read request; held high until granted
- req_addr  in  N_REQ*ADDR_W  packed read addresses; requester i occupies bits [i*ADDR_W +: ADDR_W]
- gnt  out  N_REQ  one-hot grant (combinational, same cycle as the request)
- rd_valid  out  N_REQ  one-hot return strobe (registered)
- rd_data  out  DATA_W  returned pixel, valid while any rd_valid bit is set
- rd_oob  out  1  high with rd_valid when the granted address was out of range
- wr_req  in  1  loader write request
- wr_addr  in  ADDR_W  loader write address
- wr_data  in  DATA_W  loader write data
- wr_ack  out  1  write accepted this cycle (combinational)
- oob_err  out  1  sticky flag: any out-of-range read or write seen since reset
- ram_we, ram_write_addr, ram_data_in  out  1/ADDR_W/DATA_W  drive the RAM write port
- ram_read_addr  out  ADDR_W  drives the RAM read address
- ram_data_out  in  DATA_W  RAM registered read data

## Operation
- Writes: wr_ack = wr_req, always, with no backpressure. ram_we = wr_req && wr_addr < MEM_DEPTH. ram_write_addr = wr_addr and ram_data_in = wr_data, passed through combinationally.
- An out-of-range write is acked, ram_we is suppressed, and oob_err is set.
- Read arbitration:
  - The rotating pointer ptr (log2 N_REQ bits) selects the first requester with req high, searching ptr, ptr+1, … mod N_REQ.
  - The winner w gets gnt[w] = 1 and ram_read_addr = req_addr[w].
  - On the next edge ptr <= (w+1) mod N_REQ. If no grant is issued, ptr holds.
- Read-after-write hazard: the RAM returns old data on a same-address read/write. If wr_req is high and the selected address equals wr_addr, no grant is issued this cycle. Requester w keeps its request and wins the next cycle, because ptr is unchanged.
- Out-of-range read (addr >= MEM_DEPTH):
  - The request is still granted and consumes the slot.
  - ram_read_addr is driven to 0.
  - The returned data is forced to 0, rd_oob is asserted with rd_valid, and oob_err is set.
- With no grant, ram_read_addr = 0.
- Tag pipeline:
  - Stage 1 registers {valid, id, oob} on the grant edge. The RAM data appears on ram_data_out in the following cycle.
  - Stage 2 registers rd_valid = onehot(id) & valid, rd_data = oob ? 0 : ram_data_out, and rd_oob.
- Throughput is one read per cycle; there are no bubbles except the hazard stall.
- Reset: rd_valid = 0, rd_data = 0, rd_oob = 0, oob_err = 0, ptr = 0, stage-1 valid = 0. Combinational outputs follow their inputs. An assertion of reset mid-operation discards in-flight reads and produces no rd_valid for them.

## Timing
- Cycle t: req[i] high and selected -> gnt[i] = 1 in cycle t.
- Cycle t+1: ram_data_out is valid.
- Cycle t+2: rd_valid[i] = 1, with rd_data and rd_oob valid. Latency is 2 cycles from grant to return.
- Each grant produces exactly one rd_valid pulse. Returns arrive in grant order.
- A requester sees gnt for exactly one cycle per access. If it keeps req high afterwards, it is treated as a new request.
- Writes take effect at the edge ending the wr_ack cycle. A read granted in any later cycle sees the new data.
- Simultaneous write and different-address read are both serviced in the same cycle.
- oob_err is set on the edge ending the offending cycle and clears only on reset.

## Test plan
- Reset values: hold RESET_N low, with req and wr_req toggling -> every registered output is 0, and no rd_valid appears for 3 cycles after release.
- Round robin: all 4 req high continuously, with addrs 10, 20, 30, 40 and RAM preloaded with mem[a] = a & 0xF -> grant order 0, 1, 2, 3, 0, …. rd_valid[i] follows each gnt[i] by 2 cycles, with data 0xA, 0x4, 0xE, 0x8.
- Single requester: only req[2] high for 5 cycles at address 7 -> gnt[2] is high in all 5 cycles, with 5 rd_valid[2] pulses back-to-back.
- Hazard: wr_req with wr_addr = 100, wr_data = 0x5 (old mem = 0x3), while req[1] reads 100 in the same cycle -> no gnt that cycle; gnt[1] the next cycle; return 0x5.
- Out of range: req[0] at address 2700 -> granted; ram_read_addr = 0; return data 0 with rd_oob = 1; oob_err stays 1. A write to 5000 -> wr_ack = 1, ram_we = 0.
- Reset mid-flight: assert RESET_N low one cycle after a grant -> no rd_valid emerges, and ptr restarts at 0.

Source files
------------

// File: rtl/brick_ram_arbiter.sv
// Round-robin read arbiter and write sequencer for the brick sprite RAM.
// Reads return tagged to the winning requester two cycles after the grant.
module brick_ram_arbiter #(
  parameter int N_REQ     = 4,
  parameter int ADDR_W    = 19,
  parameter int DATA_W    = 4,
  parameter int MEM_DEPTH = 2700
) (
  input  logic                      CLK,
  input  logic                      RESET_N,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  output logic [N_REQ-1:0]          gnt,
  output logic [N_REQ-1:0]          rd_valid,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      rd_oob,
  input  logic                      wr_req,
  input  logic [ADDR_W-1:0]         wr_addr,
  input  logic [DATA_W-1:0]         wr_data,
  output logic                      wr_ack,
  output logic                      oob_err,
  output logic                      ram_we,
  output logic [ADDR_W-1:0]         ram_write_addr,
  output logic [DATA_W-1:0]         ram_data_in,
  output logic [ADDR_W-1:0]         ram_read_addr,
  input  logic [DATA_W-1:0]         ram_data_out
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [ADDR_W-1:0] DEPTH = ADDR_W'(MEM_DEPTH);

  logic [PTR_W-1:0]  ptr_reg;
  logic [PTR_W-1:0]  sel;
  logic              found;
  logic              hazard;
  logic              grant;
  logic              sel_oob;
  logic              wr_oob;
  logic [ADDR_W-1:0] sel_addr;
  logic              s1_valid_reg;
  logic              s1_oob_reg;
  logic [PTR_W-1:0]  s1_id_reg;
  logic [N_REQ-1:0]  rd_valid_next;

  // First requester at or after ptr, wrapping modulo N_REQ.
  always_comb begin
    int idx;
    logic [PTR_W-1:0] idx_p;
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    idx_p = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx   = (int'(ptr_reg) + k) % N_REQ;
      idx_p = PTR_W'(idx);
      if (!found && req[idx_p]) begin
        found = 1'b1;
        sel   = idx_p;
      end
    end
  end

  assign sel_addr = req_addr[int'(sel)*ADDR_W +: ADDR_W];
  assign sel_oob  = (sel_addr >= DEPTH);
  // A same-address write would let the RAM hand back stale data; stall the read one cycle.
  assign hazard   = found && wr_req && (sel_addr == wr_addr);
  assign grant    = found && !hazard;

  assign ram_read_addr  = (grant && !sel_oob) ? sel_addr : '0;

  assign wr_oob         = (wr_addr >= DEPTH);
  assign wr_ack         = wr_req;
  assign ram_we         = wr_req && !wr_oob;
  assign ram_write_addr = wr_addr;
  assign ram_data_in    = wr_data;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_onehot
      assign gnt[gi]           = grant && (sel == PTR_W'(gi));
      assign rd_valid_next[gi] = s1_valid_reg && (s1_id_reg == PTR_W'(gi));
    end
  endgenerate

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ptr_reg      <= '0;
      s1_valid_reg <= 1'b0;
      s1_oob_reg   <= 1'b0;
      s1_id_reg    <= '0;
      rd_valid     <= '0;
      rd_data      <= '0;
      rd_oob       <= 1'b0;
      oob_err      <= 1'b0;
    end else begin
      if (grant)
        ptr_reg <= (sel == PTR_W'(N_REQ - 1)) ? '0 : sel + 1'b1;
      s1_valid_reg <= grant;
      s1_id_reg    <= sel;
      s1_oob_reg   <= sel_oob;
      rd_valid     <= rd_valid_next;
      rd_data      <= (s1_valid_reg && !s1_oob_reg) ? ram_data_out : '0;
      rd_oob       <= s1_valid_reg && s1_oob_reg;
      if ((grant && sel_oob) || (wr_req && wr_oob))
        oob_err <= 1'b1;
    end
  end

endmodule
